psram_port_arbiter: RTL

//  Shares one PSRAM controller core (start/done handshake, 24-bit addr, 32-bit data) between two
//  bus requesters (port 0: instruction fetch, port 1: data) and one mode-change requester (QPI enter/exit).

---
 rtl/psram_pkg.sv | 25 ++
 rtl/psram_port_arbiter_if.sv | 45 ++++
 rtl/psram_rr_arb2.sv | 34 +++
 rtl/psram_port_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM port arbiter: FSM encoding, requester IDs,
// transfer sizes and the opcode selection helper.
package psram_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   typedef enum logic [1:0] {
      P0   = 2'd0,
      P1   = 2'd1,
      MODE = 2'd2
   } req_id_e;

   localparam logic [2:0] SIZE_1 = 3'd1;
   localparam logic [2:0] SIZE_2 = 3'd2;
   localparam logic [2:0] SIZE_4 = 3'd4;

   function automatic logic [7:0] port_cmd(input logic rd, input logic [7:0] rd_op,
                                           input logic [7:0] wr_op);
      return rd ? rd_op : wr_op;
   endfunction

endpackage

// File: rtl/psram_port_arbiter_if.sv
// Bus bundle between the two requesters, the mode requester, the config opcodes
// and the PSRAM core. slave = arbiter side, master = environment side.
interface psram_port_arbiter_if;
   import psram_pkg::*;

   logic        p0_req, p0_rd, p0_ack, p0_err;
   logic [23:0] p0_addr;
   logic [31:0] p0_wdata, p0_rdata;
   logic [2:0]  p0_size;

   logic        p1_req, p1_rd, p1_ack, p1_err;
   logic [23:0] p1_addr;
   logic [31:0] p1_wdata, p1_rdata;
   logic [2:0]  p1_size;

   logic        mode_req, mode_exit, mode_ack;
   logic [7:0]  rd_cmd, wr_cmd, eqpi_cmd, xqpi_cmd;

   logic        core_start, core_rd_wr, core_short, core_done, busy;
   logic [23:0] core_addr;
   logic [31:0] core_data_i, core_data_o;
   logic [2:0]  core_size;
   logic [7:0]  core_cmd;

   modport slave (
      input  p0_req, p0_rd, p0_addr, p0_wdata, p0_size,
      input  p1_req, p1_rd, p1_addr, p1_wdata, p1_size,
      input  mode_req, mode_exit, rd_cmd, wr_cmd, eqpi_cmd, xqpi_cmd,
      input  core_done, core_data_o,
      output p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata, mode_ack,
      output core_start, core_addr, core_data_i, core_size, core_rd_wr, core_cmd, core_short,
      output busy
   );

   modport master (
      output p0_req, p0_rd, p0_addr, p0_wdata, p0_size,
      output p1_req, p1_rd, p1_addr, p1_wdata, p1_size,
      output mode_req, mode_exit, rd_cmd, wr_cmd, eqpi_cmd, xqpi_cmd,
      output core_done, core_data_o,
      input  p0_ack, p0_err, p0_rdata, p1_ack, p1_err, p1_rdata, mode_ack,
      input  core_start, core_addr, core_data_i, core_size, core_rd_wr, core_cmd, core_short,
      input  busy
   );

endinterface

// File: rtl/psram_rr_arb2.sv
// Two-way request picker. On a tie the pointer decides (round-robin) or port 0
// wins (fixed priority); the pointer moves away from the port just served.
module psram_rr_arb2 #(
   parameter bit RR_ENABLE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       last_gnt,
   output logic       gnt_idx,
   output logic       gnt_valid
);

   logic ptr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= 1'b0;
      end else if (advance) begin
         ptr_reg <= ~last_gnt;
      end
   end

   always_comb begin
      gnt_valid = |req;
      if (req == 2'b11) begin
         gnt_idx = RR_ENABLE ? ptr_reg : 1'b0;
      end else begin
         gnt_idx = req[1] & ~req[0];
      end
   end

endmodule

// File: rtl/psram_port_arbiter.sv
// Shares one PSRAM core between two bus ports and a QPI mode requester, sequencing
// each granted transfer IDLE -> ISSUE -> WAIT -> RESP with a watchdog on WAIT.
module psram_port_arbiter
   import psram_pkg::*;
#(
   parameter int TIMEOUT_W = 8,
   parameter bit RR_ENABLE = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   psram_port_arbiter_if.slave  bus
);

   logic [1:0]           state_reg;
   req_id_e              winner_reg;
   logic [TIMEOUT_W-1:0] wdog_reg, wdog_next;
   logic                 timeout, wait_done, wait_abort, wait_exit;
   logic                 gnt_idx, gnt_valid, rr_advance;
   logic                 mode_ack_reg;

   logic                 core_start_reg, core_rd_wr_reg, core_short_reg;
   logic [23:0]          core_addr_reg;
   logic [31:0]          core_data_reg;
   logic [2:0]           core_size_reg;
   logic [7:0]           core_cmd_reg;

   logic [1:0]           port_req, port_rd, port_win;
   logic [23:0]          port_addr  [2];
   logic [31:0]          port_wdata [2];
   logic [2:0]           port_size  [2];

   assign port_req      = {bus.p1_req, bus.p0_req};
   assign port_rd       = {bus.p1_rd, bus.p0_rd};
   assign port_addr[0]  = bus.p0_addr;
   assign port_addr[1]  = bus.p1_addr;
   assign port_wdata[0] = bus.p0_wdata;
   assign port_wdata[1] = bus.p1_wdata;
   assign port_size[0]  = bus.p0_size;
   assign port_size[1]  = bus.p1_size;
   assign port_win      = {winner_reg == P1, winner_reg == P0};

   // Saturating watchdog; abort fires on the edge where it reaches all ones.
   assign wdog_next  = (wdog_reg == '1) ? wdog_reg : wdog_reg + TIMEOUT_W'(1);
   assign timeout    = (wdog_next == '1);
   assign wait_done  = (state_reg == ST_WAIT) && bus.core_done;
   assign wait_abort = (state_reg == ST_WAIT) && !bus.core_done && timeout;
   assign wait_exit  = wait_done || wait_abort;
   assign rr_advance = (state_reg == ST_RESP) && (winner_reg != MODE);

   psram_rr_arb2 #(.RR_ENABLE(RR_ENABLE)) u_rr_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (port_req),
      .advance   (rr_advance),
      .last_gnt  (winner_reg == P1),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         winner_reg     <= P0;
         wdog_reg       <= '0;
         mode_ack_reg   <= 1'b0;
         core_start_reg <= 1'b0;
         core_rd_wr_reg <= 1'b0;
         core_short_reg <= 1'b0;
         core_addr_reg  <= '0;
         core_data_reg  <= '0;
         core_size_reg  <= '0;
         core_cmd_reg   <= '0;
      end else begin
         core_start_reg <= 1'b0;
         mode_ack_reg   <= wait_exit && (winner_reg == MODE);
         case (state_reg)
            ST_IDLE: begin
               if (bus.mode_req) begin
                  winner_reg     <= MODE;
                  core_addr_reg  <= '0;
                  core_data_reg  <= '0;
                  core_size_reg  <= '0;
                  core_rd_wr_reg <= 1'b0;
                  core_short_reg <= 1'b1;
                  core_cmd_reg   <= bus.mode_exit ? bus.xqpi_cmd : bus.eqpi_cmd;
                  state_reg      <= ST_ISSUE;
               end else if (gnt_valid) begin
                  winner_reg     <= gnt_idx ? P1 : P0;
                  core_addr_reg  <= port_addr[gnt_idx];
                  core_data_reg  <= port_wdata[gnt_idx];
                  core_size_reg  <= port_size[gnt_idx];
                  core_rd_wr_reg <= port_rd[gnt_idx];
                  core_short_reg <= 1'b0;
                  core_cmd_reg   <= port_cmd(port_rd[gnt_idx], bus.rd_cmd, bus.wr_cmd);
                  state_reg      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               core_start_reg <= 1'b1;
               wdog_reg       <= '0;
               state_reg      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_exit) begin
                  state_reg <= ST_RESP;
               end else begin
                  wdog_reg <= wdog_next;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Per-port response registers: ack/err pulse during RESP, rdata held until next read.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic        ack_reg, err_reg;
         logic [31:0] rdata_reg;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ack_reg   <= 1'b0;
               err_reg   <= 1'b0;
               rdata_reg <= '0;
            end else begin
               ack_reg <= wait_exit && port_win[gi];
               err_reg <= wait_abort && port_win[gi];
               if (wait_done && port_win[gi] && core_rd_wr_reg) begin
                  rdata_reg <= bus.core_data_o;
               end
            end
         end
      end
   endgenerate

   assign bus.p0_ack      = g_port[0].ack_reg;
   assign bus.p0_err      = g_port[0].err_reg;
   assign bus.p0_rdata    = g_port[0].rdata_reg;
   assign bus.p1_ack      = g_port[1].ack_reg;
   assign bus.p1_err      = g_port[1].err_reg;
   assign bus.p1_rdata    = g_port[1].rdata_reg;
   assign bus.mode_ack    = mode_ack_reg;
   assign bus.core_start  = core_start_reg;
   assign bus.core_addr   = core_addr_reg;
   assign bus.core_data_i = core_data_reg;
   assign bus.core_size   = core_size_reg;
   assign bus.core_rd_wr  = core_rd_wr_reg;
   assign bus.core_cmd    = core_cmd_reg;
   assign bus.core_short  = core_short_reg;
   assign bus.busy        = (state_reg != ST_IDLE);

endmodule
